// File: rtl/muldiv_unit_pkg.sv
// Shared RV32 types for the execute stage: M-extension funct3 encodings,
// multiply/divide FSM states and two's-complement helpers.
package rv32i_types;

  typedef logic [31:0] rv32i_word;

  typedef enum logic [2:0] {
    mul    = 3'b000,
    mulh   = 3'b001,
    mulhsu = 3'b010,
    mulhu  = 3'b011,
    div    = 3'b100,
    divu   = 3'b101,
    rem    = 3'b110,
    remu   = 3'b111
  } muldiv_funct3_t;

  typedef enum logic [1:0] {
    MD_IDLE = 2'b00,
    MD_CALC = 2'b01,
    MD_FIX  = 2'b10,
    MD_DONE = 2'b11
  } muldiv_state_t;

  localparam int MULDIV_ITERS = 32;

  function automatic logic [31:0] muldiv_negate32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  function automatic logic [63:0] muldiv_negate64(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide: shift-add multiply and restoring divide on
// operand magnitudes, sharing one 64-bit shift register and one 33-bit adder.
module muldiv_unit
  import rv32i_types::*;
#(
  parameter int ITERS = MULDIV_ITERS
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           start,
  input  muldiv_funct3_t funct3,
  input  rv32i_word      a,
  input  rv32i_word      b,
  input  logic           flush,
  output logic           busy,
  output logic           done,
  output rv32i_word      result
);

  localparam int CNT_W = $clog2(ITERS + 1);

  muldiv_state_t  state_r, next_state_s;
  muldiv_funct3_t op_r;
  logic [CNT_W-1:0] count_r;
  logic [63:0] acc_r;
  logic [31:0] mcand_r;
  logic        neg_r;
  logic [31:0] result_r;
  logic        busy_r, done_r;

  logic        is_div_s, signed_a_s, signed_b_s, sign_a_s, sign_b_s;
  logic [31:0] mag_a_s, mag_b_s;
  logic        div_zero_s, ovf_s, special_s, neg_s, accept_s;
  logic [31:0] special_val_s;

  logic        op_div_s;
  logic [32:0] shifted_s, add_a_s, add_b_s;
  logic [33:0] sum_s;
  logic        ge_s;
  logic [63:0] acc_next_s, prod_s;
  logic [31:0] quot_s, rmdr_s, fix_word_s;

  assign busy   = busy_r;
  assign done   = done_r;
  assign result = result_r;

  assign accept_s = (state_r == MD_IDLE) && start && !flush;

  // Request decode: operand signedness, magnitudes, result sign, special cases
  always_comb begin
    is_div_s   = funct3[2];
    signed_a_s = (funct3 == mul) || (funct3 == mulh) || (funct3 == mulhsu) ||
                 (funct3 == div) || (funct3 == rem);
    signed_b_s = (funct3 == mul) || (funct3 == mulh) ||
                 (funct3 == div) || (funct3 == rem);
    sign_a_s   = signed_a_s & a[31];
    sign_b_s   = signed_b_s & b[31];
    mag_a_s    = sign_a_s ? muldiv_negate32(a) : a;
    mag_b_s    = sign_b_s ? muldiv_negate32(b) : b;
    div_zero_s = is_div_s && (b == 32'h0000_0000);
    ovf_s      = ((funct3 == div) || (funct3 == rem)) &&
                 (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    special_s  = div_zero_s || ovf_s;
    case (funct3)
      div, divu: special_val_s = div_zero_s ? 32'hFFFF_FFFF : 32'h8000_0000;
      rem, remu: special_val_s = div_zero_s ? a : 32'h0000_0000;
      default:   special_val_s = 32'h0000_0000;
    endcase
    case (funct3)
      mul, mulh, mulhsu, div: neg_s = sign_a_s ^ sign_b_s;
      rem:                    neg_s = sign_a_s;
      default:                neg_s = 1'b0;
    endcase
  end

  // One iteration step; divide subtracts via inverted divisor plus carry-in
  always_comb begin
    op_div_s  = op_r[2];
    shifted_s = {acc_r[63:32], acc_r[31]};
    if (op_div_s) begin
      add_a_s = shifted_s;
      add_b_s = ~{1'b0, mcand_r};
    end else begin
      add_a_s = {1'b0, acc_r[63:32]};
      add_b_s = acc_r[0] ? {1'b0, mcand_r} : 33'd0;
    end
    sum_s = {1'b0, add_a_s} + {1'b0, add_b_s} + {33'd0, op_div_s};
    ge_s  = sum_s[33];
    if (op_div_s) begin
      acc_next_s = {(ge_s ? sum_s[31:0] : shifted_s[31:0]), acc_r[30:0], ge_s};
    end else begin
      acc_next_s = {sum_s[32:0], acc_r[31:1]};
    end
  end

  // Sign fix-up and result word selection
  always_comb begin
    prod_s = neg_r ? muldiv_negate64(acc_r) : acc_r;
    quot_s = neg_r ? muldiv_negate32(acc_r[31:0]) : acc_r[31:0];
    rmdr_s = neg_r ? muldiv_negate32(acc_r[63:32]) : acc_r[63:32];
    case (op_r)
      mul:                 fix_word_s = prod_s[31:0];
      mulh, mulhsu, mulhu: fix_word_s = prod_s[63:32];
      div, divu:           fix_word_s = quot_s;
      rem, remu:           fix_word_s = rmdr_s;
      default:             fix_word_s = 32'h0000_0000;
    endcase
  end

  // Next-state logic; flush has priority over everything including start
  always_comb begin
    next_state_s = state_r;
    if (flush) begin
      next_state_s = MD_IDLE;
    end else begin
      case (state_r)
        MD_IDLE: begin
          if (start) begin
            next_state_s = special_s ? MD_DONE : MD_CALC;
          end else begin
            next_state_s = MD_IDLE;
          end
        end
        MD_CALC: begin
          if (count_r == CNT_W'(ITERS - 1)) begin
            next_state_s = MD_FIX;
          end else begin
            next_state_s = MD_CALC;
          end
        end
        MD_FIX:  next_state_s = MD_DONE;
        MD_DONE: next_state_s = MD_IDLE;
        default: next_state_s = MD_IDLE;
      endcase
    end
  end

  // State register with registered status outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= MD_IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s != MD_IDLE);
      done_r  <= (next_state_s == MD_DONE);
    end
  end

  // Operand capture, iteration datapath and result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_r     <= mul;
      count_r  <= '0;
      acc_r    <= 64'd0;
      mcand_r  <= 32'd0;
      neg_r    <= 1'b0;
      result_r <= 32'h0000_0000;
    end else if (accept_s) begin
      op_r    <= funct3;
      count_r <= '0;
      neg_r   <= neg_s;
      mcand_r <= is_div_s ? mag_b_s : mag_a_s;
      acc_r   <= {32'd0, (is_div_s ? mag_a_s : mag_b_s)};
      if (special_s) begin
        result_r <= special_val_s;
      end else begin
        result_r <= result_r;
      end
    end else if (state_r == MD_CALC) begin
      acc_r   <= acc_next_s;
      count_r <= count_r + CNT_W'(1);
    end else if ((state_r == MD_FIX) && !flush) begin
      result_r <= fix_word_s;
    end else begin
      result_r <= result_r;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: an arithmetic reference model with a
// latency countdown is compared every cycle, plus literal expectations.
module tb_muldiv_unit;
  import rv32i_types::*;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           start = 1'b0;
  logic           flush = 1'b0;
  muldiv_funct3_t funct3 = mul;
  logic [31:0]    a = 32'd0;
  logic [31:0]    b = 32'd0;
  logic           busy, done;
  logic [31:0]    result;

  int errors = 0;
  int checks = 0;

  int          m_rem = 0;
  logic [31:0] m_pend = 32'd0;
  logic [31:0] m_result = 32'd0;

  always #5 clk = ~clk;

  muldiv_unit dut (
    .clk(clk), .rst_n(rst_n), .start(start), .funct3(funct3),
    .a(a), .b(b), .flush(flush), .busy(busy), .done(done), .result(result)
  );

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  function automatic logic is_special(input muldiv_funct3_t op, input logic [31:0] x, input logic [31:0] y);
    return op[2] && ((y == 32'd0) ||
           ((op == div || op == rem) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
  endfunction

  function automatic logic [31:0] model(input muldiv_funct3_t op, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, ux, uy, p;
    int ix, iy;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    ux = longint'({32'd0, x});
    uy = longint'({32'd0, y});
    ix = $signed(x);
    iy = $signed(y);
    case (op)
      mul:    begin p = sx * sy; return p[31:0];  end
      mulh:   begin p = sx * sy; return p[63:32]; end
      mulhsu: begin p = sx * uy; return p[63:32]; end
      mulhu:  begin p = ux * uy; return p[63:32]; end
      div:    if (y == 32'd0) return 32'hFFFF_FFFF;
              else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
              else return ix / iy;
      divu:   if (y == 32'd0) return 32'hFFFF_FFFF; else return x / y;
      rem:    if (y == 32'd0) return x;
              else if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
              else return ix % iy;
      remu:   if (y == 32'd0) return x; else return x % y;
      default: return 32'd0;
    endcase
  endfunction

  // Reference timeline: m_rem counts down to the done cycle (1 = done cycle)
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem    <= 0;
      m_result <= 32'd0;
    end else if (flush) begin
      m_rem <= 0;
    end else if (m_rem == 0) begin
      if (start) begin
        m_pend <= model(funct3, a, b);
        m_rem  <= is_special(funct3, a, b) ? 1 : 34;
        if (is_special(funct3, a, b)) m_result <= model(funct3, a, b);
      end
    end else begin
      m_rem <= m_rem - 1;
      if (m_rem == 2) m_result <= m_pend;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("busy", {31'd0, busy}, {31'd0, (m_rem != 0)});
      check("done", {31'd0, done}, {31'd0, (m_rem == 1)});
      check("result", result, m_result);
    end
  end

  task automatic issue(input muldiv_funct3_t op, input logic [31:0] x, input logic [31:0] y);
    @(posedge clk); #1;
    start = 1'b1; funct3 = op; a = x; b = y;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 1;
    while (!done && n < 60) begin
      @(posedge clk); #1;
      n++;
    end
    if (!done) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run(input muldiv_funct3_t op, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] exp, input int lat, input string nm);
    int n;
    issue(op, x, y);
    wait_done(n);
    check(nm, result, exp);
    check({nm, "_latency"}, 32'(n), 32'(lat));
    @(posedge clk); #1;
  endtask

  initial begin
    int  n;
    logic seen;
    #1;
    check("reset_busy", {31'd0, busy}, 32'd0);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Model pins
    check("model_mul", model(mul, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    check("model_rem", model(rem, 32'hFFFF_FFF9, 32'd2), 32'hFFFF_FFFF);

    run(mul,    32'd7,        32'hFFFF_FFFD, 32'hFFFF_FFEB, 34, "mul");
    run(mulh,   32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 34, "mulh");
    run(mulhu,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 34, "mulhu");
    run(mulhsu, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 34, "mulhsu");
    run(div,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFD, 34, "div_neg");
    run(rem,    32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 34, "rem_neg");
    run(divu,   32'd100,      32'd7,         32'd14,        34, "divu");
    run(remu,   32'd100,      32'd7,         32'd2,         34, "remu");

    // Flush in cycle 10 of a mul
    issue(mul, 32'd123, 32'd456);
    repeat (9) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {31'd0, busy}, 32'd0);
    check("flush_result", result, 32'd2);
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done) seen = 1'b1; end
    check("flush_no_done", {31'd0, seen}, 32'd0);

    run(div,  32'd5,        32'd0,         32'hFFFF_FFFF, 1, "div_by_zero");
    run(rem,  32'd5,        32'd0,         32'd5,         1, "rem_by_zero");
    run(div,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, "div_ovf");
    run(rem,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         1, "rem_ovf");

    // Start pulsed in cycle 5 of an active op is ignored
    issue(mulh, 32'h8000_0000, 32'h8000_0000);
    repeat (4) begin @(posedge clk); #1; end
    start = 1'b1; funct3 = mul; a = 32'd7; b = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    wait_done(n);
    check("ignored_start", result, 32'h4000_0000);
    check("ignored_start_latency", 32'(n + 5), 32'd34);
    @(posedge clk); #1;

    // Reset in cycle 20 of a div
    issue(div, 32'd1000, 32'd3);
    repeat (19) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_result", result, 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (done) seen = 1'b1; end
    check("rst_no_done", {31'd0, seen}, 32'd0);
    run(divu, 32'd100, 32'd7, 32'd14, 34, "after_reset");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit in the execute stage, beside the ALU. It consumes operands plus the `muldiv_funct3_t` op from the decoded instruction (op_reg with funct7 = 0000001; that decode happens upstream). It returns a 32-bit result for the regfile writeback path, and stalls the pipeline through `busy` while iterating.

## Interface
- `ITERS`, 32: iteration count; must equal operand width.
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: reset, asynchronous, active-low.
- `start` in 1: request; accepted only in IDLE.
- `funct3` in 3 (`muldiv_funct3_t`): operation; sampled with `start`.
- `a` in 32 (`rv32i_word`): rs1 value / dividend; sampled with `start`.
- `b` in 32 (`rv32i_word`): rs2 value / divisor; sampled with `start`.
- `flush` in 1: kill the in-flight op (branch mispredict / pipeline flush).
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse; `result` is valid this cycle.
- `result` out 32 (`rv32i_word`): registered result, held until the next completion.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - `start` && !`flush`: latch the op, take operand magnitudes, record the result sign, clear iteration count.
  - Special-case div/divu/rem/remu → DONE; otherwise → CALC.
- Operand sign handling:
  - Signed operands: mul/mulh a and b; mulhsu a only; div/rem a and b.
  - Unsigned operands: mulhu, divu, remu.
- Multiply (CALC):
  - Shift-add on magnitudes into a 64-bit product, one multiplier bit per cycle, 32 cycles.
  - Product sign = sign(a) XOR sign(b) over the signed operands only.
- Divide (CALC):
  - Restoring division on magnitudes, 33-bit partial remainder, one quotient bit per cycle, 32 cycles.
  - Quotient sign = sign(a) XOR sign(b) (div only); remainder takes the sign of a (rem only).
- FIX (1 cycle):
  - Two's-complement negate if the recorded sign is set.
  - Select the result word into `result`:
    - mul: product[31:0]; mulh, mulhsu, mulhu: product[63:32].
    - div, divu: quotient; rem, remu: remainder.
  - → DONE.
- DONE: `done`=1 for exactly one cycle, → IDLE.
- Special cases, resolved in IDLE, with `result` loaded on that edge:
  - Divisor 0: div/divu → 0xFFFFFFFF; rem/remu → a.
  - Signed overflow, a=0x80000000 and b=0xFFFFFFFF: div → 0x80000000; rem → 0.
- `flush` in any state: → IDLE on the next edge. `done` is not asserted and `result` is unchanged. `flush` wins over a same-cycle `start`.
- `start` while `busy`: ignored.
- Internal operand/accumulator registers are don't-care outside CALC/FIX.

## Timing
- Reset (async, immediate): state IDLE, `busy`=0, `done`=0, `result`=0x00000000, count=0.
- Normal path (`start` accepted in cycle 0):
  - CALC in cycles 1–32, FIX in cycle 33.
  - DONE in cycle 34: `done`=1 with `result` valid.
  - IDLE in cycle 35. Latency is 34 cycles.
- Special-case path: DONE in cycle 1; latency is 1 cycle.
- `busy` goes high in cycle 1 and low in the first IDLE cycle. The next `start` is accepted no earlier than cycle 35 (cycle 2 for special cases).
- `done` and `busy` are both high in the DONE cycle; the stall releases after `done`.
- `rst_n` deasserting mid-operation: the unit restarts in IDLE. The aborted op never produces `done`.

## Structure
- `rv32i_types` additions:
  - `muldiv_state_t` enum (IDLE, CALC, FIX, DONE).
  - `MULDIV_ITERS` = 32.
- Reuse the existing `muldiv_funct3_t` for `funct3`.
- Single module. Multiply and divide share one 64-bit shift register and one 33-bit adder/subtractor; no sub-module is required.
- An optional helper `muldiv_negate` (32/64-bit two's-complement) is natural for the IDLE magnitude step and the FIX sign step.

## Test plan
- mul: a=7, b=0xFFFFFFFD (−3) → `result`=0xFFFFFFEB, `done` in cycle 34, `busy` high in cycles 1–34.
- High-word multiplies:
  - mulh 0x80000000×0x80000000 → 0x40000000.
  - mulhu 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - mulhsu 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Divide and remainder:
  - div −7/2 → 0xFFFFFFFD; rem −7/2 → 0xFFFFFFFF.
  - divu 100/7 → 14; remu 100/7 → 2.
- Special cases, each with `done` in cycle 1:
  - div 5/0 → 0xFFFFFFFF; rem 5/0 → 5.
  - div 0x80000000/0xFFFFFFFF → 0x80000000; rem → 0.
- Flush and ignored start:
  - `flush` in cycle 10 of a mul → `busy`=0 in cycle 11, no `done`, `result` keeps the prior value.
  - `start` pulsed in cycle 5 of an active op → ignored; the original op completes correctly.
- `rst_n` low in cycle 20 of a div → `busy`, `done`, `result` = 0 immediately; no `done` after release; the next op completes normally.
